// File: rtl/ddr_init_pkg.sv
// Shared definitions for the DDR controller init responder: state encodings,
// counter widths and default timing parameters.
package ddr_init_pkg;

   localparam int unsigned LOCK_W  = 16;
   localparam int unsigned TIMER_W = 20;
   localparam int unsigned RETRY_W = 4;
   localparam int unsigned GAP_W   = 8;
   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] STATE_WAIT_LOCK  = 3'd0;
   localparam logic [STATE_W-1:0] STATE_START      = 3'd1;
   localparam logic [STATE_W-1:0] STATE_TRAIN      = 3'd2;
   localparam logic [STATE_W-1:0] STATE_RETRY_WAIT = 3'd3;
   localparam logic [STATE_W-1:0] STATE_READY      = 3'd4;
   localparam logic [STATE_W-1:0] STATE_FAIL       = 3'd5;

   typedef enum logic [STATE_W-1:0] {
      ST_WAIT_LOCK  = STATE_WAIT_LOCK,
      ST_START      = STATE_START,
      ST_TRAIN      = STATE_TRAIN,
      ST_RETRY_WAIT = STATE_RETRY_WAIT,
      ST_READY      = STATE_READY,
      ST_FAIL       = STATE_FAIL
   } init_state_e;

   localparam logic [LOCK_W-1:0]  LOCK_STABLE_DEF   = 16'h03FF;
   localparam logic [TIMER_W-1:0] TRAIN_TIMEOUT_DEF = 20'hFFFFF;
   localparam logic [RETRY_W-1:0] MAX_RETRY_DEF     = 4'h3;
   localparam logic [GAP_W-1:0]   RETRY_GAP_DEF     = 8'h40;

endpackage

// File: rtl/ddr_lock_qualifier.sv
// Counts consecutive pll_lock cycles; lock_ok fires on the cycle the count
// reaches LOCK_STABLE with lock still high. clear forces the count back to zero.
module ddr_lock_qualifier
   import ddr_init_pkg::*;
#(
   parameter logic [LOCK_W-1:0] LOCK_STABLE = LOCK_STABLE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_lock,
   input  logic clear,
   output logic lock_ok
);

   logic [LOCK_W-1:0] lock_cnt_q;
   logic [LOCK_W-1:0] lock_cnt_d;

   // Saturate at LOCK_STABLE so the counter cannot wrap while the owner is busy leaving.
   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (clear || !pll_lock) begin
         lock_cnt_d = {LOCK_W{1'b0}};
      end else if (lock_cnt_q == LOCK_STABLE) begin
         lock_cnt_d = lock_cnt_q;
      end else begin
         lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
   end

   assign lock_ok = pll_lock && !clear && (lock_cnt_q == LOCK_STABLE);

   // Lock stability counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_cnt_q <= {LOCK_W{1'b0}};
      end else begin
         lock_cnt_q <= lock_cnt_d;
      end
   end

endmodule

// File: rtl/ddr_ctrlr_ready_gen.sv
// Controller-side DDR init responder: lock qualification, training supervision
// with timeout/retry, ctrlr_ready/init_fail reporting. Option: DDR_LOCK_LOSS_REINIT_EN.
module ddr_ctrlr_ready_gen
   import ddr_init_pkg::*;
#(
   parameter logic [LOCK_W-1:0]  LOCK_STABLE   = LOCK_STABLE_DEF,
   parameter logic [TIMER_W-1:0] TRAIN_TIMEOUT = TRAIN_TIMEOUT_DEF,
   parameter logic [RETRY_W-1:0] MAX_RETRY     = MAX_RETRY_DEF,
   parameter logic [GAP_W-1:0]   RETRY_GAP     = RETRY_GAP_DEF
) (
   input  logic               clk,
   input  logic               SYS_RESET_IN_N,
   input  logic               pll_lock,
   input  logic               train_done,
   input  logic               train_err,
   output logic               train_start,
   output logic               ctrlr_ready,
   output logic               init_fail,
   output logic [RETRY_W-1:0] retry_count,
   output logic [STATE_W-1:0] init_state
);

   localparam logic [GAP_W-1:0] GAP_LAST = RETRY_GAP - GAP_W'(1);

   init_state_e        state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               train_start_q, train_start_d;
   logic               ready_q, ready_d;
   logic               fail_q, fail_d;
   logic               lock_ok;
   logic               attempt_fail;

   ddr_lock_qualifier #(
      .LOCK_STABLE (LOCK_STABLE)
   ) u_lock_qual (
      .clk      (clk),
      .rst_n    (SYS_RESET_IN_N),
      .pll_lock (pll_lock),
      .clear    (state_q != ST_WAIT_LOCK),
      .lock_ok  (lock_ok)
   );

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      retry_d      = retry_q;
      gap_d        = gap_q;
      attempt_fail = 1'b0;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (lock_ok) begin
               state_d = ST_START;
            end else begin
               state_d = ST_WAIT_LOCK;
            end
         end
         ST_START: begin
            timer_d = {TIMER_W{1'b0}};
            state_d = ST_TRAIN;
         end
         ST_TRAIN: begin
            // Lock loss beats error beats done beats timeout.
            if (!pll_lock || train_err) begin
               attempt_fail = 1'b1;
            end else if (train_done) begin
               state_d = ST_READY;
            end else if (timer_q == TRAIN_TIMEOUT) begin
               attempt_fail = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_RETRY_WAIT: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_WAIT_LOCK;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         ST_READY: begin
`ifdef DDR_LOCK_LOSS_REINIT_EN
            if (!pll_lock) begin
               state_d = ST_WAIT_LOCK;
            end else begin
               state_d = ST_READY;
            end
`else
            state_d = ST_READY;
`endif
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d = ST_WAIT_LOCK;
         end
      endcase

      if (attempt_fail) begin
         if (retry_q == MAX_RETRY) begin
            state_d = ST_FAIL;
         end else begin
            retry_d = retry_q + RETRY_W'(1);
            gap_d   = {GAP_W{1'b0}};
            state_d = ST_RETRY_WAIT;
         end
      end else begin
         retry_d = retry_d;
      end

      train_start_d = (state_d == ST_START);
      ready_d       = (state_d == ST_READY);
      fail_d        = (state_d == ST_FAIL);
   end

   // State, counters and outputs; reset wins in every state.
   always_ff @(posedge clk) begin
      if (!SYS_RESET_IN_N) begin
         state_q       <= ST_WAIT_LOCK;
         timer_q       <= {TIMER_W{1'b0}};
         retry_q       <= {RETRY_W{1'b0}};
         gap_q         <= {GAP_W{1'b0}};
         train_start_q <= 1'b0;
         ready_q       <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         retry_q       <= retry_d;
         gap_q         <= gap_d;
         train_start_q <= train_start_d;
         ready_q       <= ready_d;
         fail_q        <= fail_d;
      end
   end

   assign train_start = train_start_q;
   assign ctrlr_ready = ready_q;
   assign init_fail   = fail_q;
   assign retry_count = retry_q;
   assign init_state  = state_q;

endmodule

// File: tb/tb_ddr_ctrlr_ready_gen.sv
// Directed, table-driven bench for ddr_ctrlr_ready_gen with small timing parameters.
module tb_ddr_ctrlr_ready_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       train_done;
   logic       train_err;
   logic       train_start;
   logic       ctrlr_ready;
   logic       init_fail;
   logic [3:0] retry_count;
   logic [2:0] init_state;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       rst_n;
      logic       lock;
      logic       done;
      logic       err;
      int         ncyc;
      logic [2:0] st;
      logic       start;
      logic       rdy;
      logic       fail;
      logic [3:0] retry;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   ddr_ctrlr_ready_gen #(
      .LOCK_STABLE   (16'd8),
      .TRAIN_TIMEOUT (20'd100),
      .MAX_RETRY     (4'd2),
      .RETRY_GAP     (8'd4)
   ) dut (
      .clk            (clk),
      .SYS_RESET_IN_N (rst_n),
      .pll_lock       (pll_lock),
      .train_done     (train_done),
      .train_err      (train_err),
      .train_start    (train_start),
      .ctrlr_ready    (ctrlr_ready),
      .init_fail      (init_fail),
      .retry_count    (retry_count),
      .init_state     (init_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic l, input logic d, input logic e, input int n,
                      input logic [2:0] st, input logic s, input logic rd, input logic f,
                      input logic [3:0] rt);
      vec_t v;
      v.rst_n = r; v.lock = l; v.done = d; v.err = e; v.ncyc = n;
      v.st = st; v.start = s; v.rdy = rd; v.fail = f; v.retry = rt;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; pll_lock = 1'b0; train_done = 1'b0; train_err = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      int npulse;
      int p[3];

      rst_n = 1'b0; pll_lock = 1'b0; train_done = 1'b0; train_err = 1'b0;
      #2;

      //   rst lock done err  n   st  s  r  f  retry
      // basic bring-up: 9 locked clk, START pulse, train_done -> READY
      add(0, 1, 0, 0,   2, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0,   8, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0,   1, 1, 1, 0, 0, 0);
      add(1, 1, 0, 0,   1, 2, 0, 0, 0, 0);
      add(1, 1, 0, 0,  19, 2, 0, 0, 0, 0);
      add(1, 1, 1, 0,   1, 4, 0, 1, 0, 0);
`ifdef DDR_LOCK_LOSS_REINIT_EN
      add(1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0,   2, 0, 0, 0, 0, 0);
`else
      add(1, 0, 0, 0,   1, 4, 0, 1, 0, 0);
      add(1, 0, 0, 0,   2, 4, 0, 1, 0, 0);
`endif
      add(0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
      // timeout on the 101st TRAIN cycle, then a done+err collision, then FAIL
      add(1, 1, 0, 0,   9, 1, 1, 0, 0, 0);
      add(1, 1, 0, 0,   1, 2, 0, 0, 0, 0);
      add(1, 1, 0, 0, 100, 2, 0, 0, 0, 0);
      add(1, 1, 0, 0,   1, 3, 0, 0, 0, 1);
      add(1, 1, 0, 0,   3, 3, 0, 0, 0, 1);
      add(1, 1, 0, 0,   1, 0, 0, 0, 0, 1);
      add(1, 1, 0, 0,   9, 1, 1, 0, 0, 1);
      add(1, 1, 0, 0,   1, 2, 0, 0, 0, 1);
      add(1, 1, 1, 1,   1, 3, 0, 0, 0, 2);
      add(1, 1, 0, 0,   4, 0, 0, 0, 0, 2);
      add(1, 1, 0, 0,   9, 1, 1, 0, 0, 2);
      add(1, 1, 0, 0,   1, 2, 0, 0, 0, 2);
      add(1, 1, 0, 1,   1, 5, 0, 0, 1, 2);
      add(1, 1, 1, 0,   3, 5, 0, 0, 1, 2);
      // reset mid-TRAIN; later train_done ignored; lock loss in TRAIN is a failure
      add(0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0,  10, 2, 0, 0, 0, 0);
      add(0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
      add(1, 1, 1, 0,   5, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0,   4, 1, 1, 0, 0, 0);
      add(1, 1, 0, 0,   1, 2, 0, 0, 0, 0);
      add(1, 0, 0, 0,   1, 3, 0, 0, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n      = vecs[i].rst_n;
         pll_lock   = vecs[i].lock;
         train_done = vecs[i].done;
         train_err  = vecs[i].err;
         repeat (vecs[i].ncyc) tick();
         chk($sformatf("vec%0d.init_state", i),  int'(init_state),  int'(vecs[i].st));
         chk($sformatf("vec%0d.train_start", i), int'(train_start), int'(vecs[i].start));
         chk($sformatf("vec%0d.ctrlr_ready", i), int'(ctrlr_ready), int'(vecs[i].rdy));
         chk($sformatf("vec%0d.init_fail", i),   int'(init_fail),   int'(vecs[i].fail));
         chk($sformatf("vec%0d.retry_count", i), int'(retry_count), int'(vecs[i].retry));
      end

      // Lock glitch after 5 locked clk restarts qualification from zero.
      do_reset();
      pll_lock = 1'b1;
      repeat (5) tick();
      pll_lock = 1'b0;
      tick();
      chk("glitch.state", int'(init_state), 0);
      pll_lock = 1'b1;
      n = 0;
      while (train_start !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("glitch.locked_clk_to_start", n, 9);
      chk("glitch.start_state", int'(init_state), 1);

      // Persistent train_err: three attempts, 15 clk apart, then FAIL.
      do_reset();
      pll_lock  = 1'b1;
      train_err = 1'b1;
      npulse = 0;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (train_start === 1'b1) begin
            if (npulse < 3) p[npulse] = c;
            npulse++;
         end
         if (init_fail === 1'b1) break;
      end
      chk("retry.pulse_count", npulse, 3);
      if (npulse >= 3) begin
         chk("retry.first_pulse", p[0], 9);
         chk("retry.gap1", p[1] - p[0], 15);
         chk("retry.gap2", p[2] - p[1], 15);
      end
      chk("retry.init_fail", int'(init_fail), 1);
      chk("retry.retry_count", int'(retry_count), 2);
      chk("retry.init_state", int'(init_state), 5);
      chk("retry.ctrlr_ready", int'(ctrlr_ready), 0);
      tick();
      chk("retry.fail_sticky", int'(init_fail), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
